lift_dispatcher: RTL
====================

// Module: lift_dispatcher
// PURPOSE
//  Parametrised multi-car lift controller: successor to the combinational zone lookup.
//  Floors are split into contiguous zones, one per car. Each accepted call is routed to its zone's car.
//  Each car runs a clocked SCAN state machine with floor-travel and door timers.
//  Sits between the floor call-button encoder and the per-car motor/door drivers.
// PARAMETERS
//  N_FLOORS    10  floors served, numbered 1..N_FLOORS (floor 1 = ground)
//  N_CARS      4   cars; ZONE = ceil(N_FLOORS/N_CARS); car k serves floors k*ZONE+1 .. min((k+1)*ZONE, N_FLOORS)
//  TRAVEL_CYC  4   clock cycles to move one floor (>=1)
//  DOOR_CYC    3   clock cycles door stays open (>=1)
//  FW          4   floor field width; must satisfy 2^FW > N_FLOORS
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous, active-high reset
//  req_valid    in   1            call request strobe
//  req_floor    in   FW           calling floor
//  req_ready    out  1            1 when a request is accepted this cycle
//  grant_valid  out  1            registered, 1 cycle after acceptance
//  grant_car    out  clog2(N_CARS) car assigned to the call
//  grant_wait   out  16           estimated wait: |car_floor-req_floor|*TRAVEL_CYC, saturating
//  req_err      out  1            1-cycle pulse: request with floor 0 or floor > N_FLOORS
//  car_floor    out  N_CARS*FW    current floor per car, car k at bits [k*FW +: FW]
//  car_moving   out  N_CARS       car in MOVE
//  door_open    out  N_CARS       car in DOOR
//  arrive       out  N_CARS       1-cycle pulse when car enters DOOR
// BEHAVIOUR
//  Reset (async, immediate):
//   - every car: IDLE, pending cleared, dir = up, car_floor = zone base floor
//   - outputs: grant_valid=0, req_err=0, arrive=0, car_moving=0, door_open=0, req_ready=0
//   - timers are cleared; reset mid-move discards the move and all pending calls
//  Request handshake:
//   - req_ready = !rst, combinational
//   - accept = req_valid & req_ready & legal floor
//   - accept sets the pending bit for req_floor in the owning car; the bit is visible to that car's FSM on the next cycle
//   - duplicate call to an already-pending floor: accepted and granted, no extra state
//   - illegal floor: no pending update, grant_valid=0, req_err=1 on the next cycle
//  Per-car FSM (IDLE, MOVE, DOOR); timer counts down:
//   - IDLE, pending at current floor: clear bit -> DOOR, timer=DOOR_CYC-1, arrive pulse
//   - IDLE, other pending: choose dir, preferring the current dir if pending exists that way -> MOVE, timer=TRAVEL_CYC-1
//   - MOVE: timer reaches 0 -> car_floor +/- 1; then
//       - if pending at the new floor: clear bit -> DOOR, timer=DOOR_CYC-1, arrive pulse
//       - else: reload timer, keep moving
//   - DOOR: a call to the current floor clears its bit and restarts timer=DOOR_CYC-1 (door extension, no new arrive pulse)
//   - DOOR, timer 0: pending ahead in dir -> MOVE; pending only behind -> flip dir, MOVE; none -> IDLE
//   - car never leaves its zone; the floor counter saturates at zone bounds
//  Pass-through calls:
//   - a call for a floor the car is currently traversing is served only when the car enters that floor
//   - a call accepted in the same cycle the car increments onto that floor is served on the next pass
//  grant_wait:
//   - uses car_floor at acceptance time
//   - 0 when the car is already at the called floor
// STRUCTURE
//  Shared package lift_pkg:
//   - car state enum {IDLE, MOVE, DOOR}
//   - clog2 function and ZONE computation
//   - floor_to_car() function
//  Sub-module lift_car: one FSM, timer and pending vector; generate-instantiated N_CARS times.
//  Top level holds: request decode, error pulse and grant register.
// TESTING (defaults unless stated)
//  1. rst pulse mid-MOVE -> all outputs at reset values; car_floor = {10,7,4,1} (car3..car0)
//  2. call floor 1 while car0 IDLE at 1 -> grant_car=0, grant_wait=0; arrive[0] next cycle; door_open[0] for 3 cycles
//  3. call floor 3 -> grant_car=0, grant_wait=8; car0 reaches 3 after 8 cycles of MOVE; arrive[0] pulses
//  4. car1 at 4 moving up to 6; call 5 then 4 -> stops at 5, then reverses and stops at 4; two arrive[1] pulses
//  5. req_floor=0 and req_floor=11 -> req_err pulse each; no grant; pending unchanged
//  6. simultaneous calls to floors 2 and 9 on back-to-back cycles -> cars 0 and 2 move concurrently; both arrive pulses occur

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and elaboration-time helpers for the multi-car lift dispatcher.
package lift_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } car_state_t;

   localparam int WAIT_W = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Port and counter widths never collapse to zero bits.
   function automatic int width_of(input int count);
      return (clog2(count) > 0) ? clog2(count) : 1;
   endfunction

   function automatic int zone_size(input int n_floors, input int n_cars);
      return (n_floors + n_cars - 1) / n_cars;
   endfunction

   function automatic int floor_to_car(input int floor, input int zone);
      return (floor - 1) / zone;
   endfunction

endpackage

// File: rtl/lift_car.sv
// One lift car: SCAN sequencing over its own zone, with floor-travel and door timers.
module lift_car
   import lift_pkg::*;
#(
   parameter int FW         = 4,
   parameter int ZONE       = 3,
   parameter int BASE       = 1,
   parameter int TOP        = 3,
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_set_valid,
   input  logic [FW-1:0] i_set_floor,
   output logic [FW-1:0] o_floor,
   output logic          o_moving,
   output logic          o_door_open,
   output logic          o_arrive
);

   localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int TW   = width_of(TMAX);

   localparam logic [TW-1:0] TRAVEL_T = TW'(TRAVEL_CYC - 1);
   localparam logic [TW-1:0] DOOR_T   = TW'(DOOR_CYC - 1);
   localparam logic [TW-1:0] TIMER_1  = TW'(1);
   localparam logic [FW-1:0] BASE_F   = FW'(BASE);
   localparam logic [FW-1:0] TOP_F    = FW'(TOP);
   localparam logic [FW-1:0] FLOOR_1  = FW'(1);

   car_state_t      r_state;
   car_state_t      w_state_nx;
   logic [TW-1:0]   r_timer;
   logic [TW-1:0]   w_timer_nx;
   logic [FW-1:0]   r_floor;
   logic [FW-1:0]   w_floor_nx;
   logic            r_dir_up;
   logic            w_dir_nx;
   logic            r_arrive;
   logic            w_arrive_nx;
   logic [ZONE-1:0] r_pending;
   logic [ZONE-1:0] w_set_mask;
   logic [ZONE-1:0] w_clr_mask;
   logic [FW-1:0]   w_cur_off;
   logic [FW-1:0]   w_set_off;
   logic [FW-1:0]   w_step_floor;
   logic [FW-1:0]   w_step_off;
   logic [FW-1:0]   w_clr_off;
   logic            w_clr_en;
   logic            w_here;
   logic            w_above;
   logic            w_below;
   logic            w_ahead;
   logic            w_behind;
   logic            w_step_hit;

   assign w_cur_off = r_floor - BASE_F;
   assign w_set_off = i_set_floor - BASE_F;

   // The floor reached after one travel period, pinned at the zone bounds.
   always_comb begin
      w_step_floor = r_floor;
      if (r_dir_up && (r_floor != TOP_F)) begin
         w_step_floor = r_floor + FLOOR_1;
      end else if (!r_dir_up && (r_floor != BASE_F)) begin
         w_step_floor = r_floor - FLOOR_1;
      end
   end

   assign w_step_off = w_step_floor - BASE_F;

   always_comb begin
      w_here     = 1'b0;
      w_above    = 1'b0;
      w_below    = 1'b0;
      w_step_hit = 1'b0;
      for (int i = 0; i < ZONE; i++) begin
         if (r_pending[i]) begin
            if (FW'(i) == w_cur_off)  w_here     = 1'b1;
            if (FW'(i) >  w_cur_off)  w_above    = 1'b1;
            if (FW'(i) <  w_cur_off)  w_below    = 1'b1;
            if (FW'(i) == w_step_off) w_step_hit = 1'b1;
         end
      end
   end

   assign w_ahead  = r_dir_up ? w_above : w_below;
   assign w_behind = r_dir_up ? w_below : w_above;

   always_comb begin
      w_state_nx  = r_state;
      w_timer_nx  = r_timer;
      w_floor_nx  = r_floor;
      w_dir_nx    = r_dir_up;
      w_arrive_nx = 1'b0;
      w_clr_en    = 1'b0;
      w_clr_off   = w_cur_off;
      case (r_state)
         IDLE: begin
            if (w_here) begin
               w_state_nx  = DOOR;
               w_timer_nx  = DOOR_T;
               w_arrive_nx = 1'b1;
               w_clr_en    = 1'b1;
            end else if (w_above || w_below) begin
               w_dir_nx   = w_ahead ? r_dir_up : !r_dir_up;
               w_state_nx = MOVE;
               w_timer_nx = TRAVEL_T;
            end
         end
         MOVE: begin
            if (r_timer != '0) begin
               w_timer_nx = r_timer - TIMER_1;
            end else if (!w_ahead) begin
               w_state_nx = IDLE;
            end else begin
               w_floor_nx = w_step_floor;
               if (w_step_hit) begin
                  w_state_nx  = DOOR;
                  w_timer_nx  = DOOR_T;
                  w_arrive_nx = 1'b1;
                  w_clr_en    = 1'b1;
                  w_clr_off   = w_step_off;
               end else begin
                  w_timer_nx = TRAVEL_T;
               end
            end
         end
         DOOR: begin
            // A fresh call to this floor holds the door open without a new arrival.
            if (w_here) begin
               w_timer_nx = DOOR_T;
               w_clr_en   = 1'b1;
            end else if (r_timer != '0) begin
               w_timer_nx = r_timer - TIMER_1;
            end else if (w_ahead) begin
               w_state_nx = MOVE;
               w_timer_nx = TRAVEL_T;
            end else if (w_behind) begin
               w_dir_nx   = !r_dir_up;
               w_state_nx = MOVE;
               w_timer_nx = TRAVEL_T;
            end else begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // A call landing in the same cycle as a clear survives, so it is served on a later pass.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int i = 0; i < ZONE; i++) begin
         w_set_mask[i] = i_set_valid && (FW'(i) == w_set_off);
         w_clr_mask[i] = w_clr_en && (FW'(i) == w_clr_off);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_floor   <= BASE_F;
         r_dir_up  <= 1'b1;
         r_arrive  <= 1'b0;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_timer   <= w_timer_nx;
         r_floor   <= w_floor_nx;
         r_dir_up  <= w_dir_nx;
         r_arrive  <= w_arrive_nx;
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      end
   end

   assign o_floor     = r_floor;
   assign o_moving    = (r_state == MOVE);
   assign o_door_open = (r_state == DOOR);
   assign o_arrive    = r_arrive;

endmodule

// File: rtl/lift_dispatcher.sv
// Multi-car lift dispatcher: decodes call requests, routes each to its zone's car and reports grants.
module lift_dispatcher
   import lift_pkg::*;
#(
   parameter int N_FLOORS   = 10,
   parameter int N_CARS     = 4,
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 3,
   parameter int FW         = 4,
   localparam int CAR_W     = width_of(N_CARS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req_valid,
   input  logic [FW-1:0]        i_req_floor,
   output logic                 o_req_ready,
   output logic                 o_grant_valid,
   output logic [CAR_W-1:0]     o_grant_car,
   output logic [WAIT_W-1:0]    o_grant_wait,
   output logic                 o_req_err,
   output logic [N_CARS*FW-1:0] o_car_floor,
   output logic [N_CARS-1:0]    o_car_moving,
   output logic [N_CARS-1:0]    o_door_open,
   output logic [N_CARS-1:0]    o_arrive
);

   localparam int              ZONE      = zone_size(N_FLOORS, N_CARS);
   localparam logic [FW-1:0]   MAX_FLOOR = FW'(N_FLOORS);

   logic                 w_legal;
   logic                 w_accept;
   logic                 w_illegal;
   logic [CAR_W-1:0]     w_car;
   logic [FW-1:0]        w_sel_floor;
   logic [FW-1:0]        w_dist;
   logic [47:0]          w_wait_full;
   logic [WAIT_W-1:0]    w_wait;
   logic [N_CARS*FW-1:0] w_car_floor;
   logic [N_CARS-1:0]    w_car_moving;
   logic [N_CARS-1:0]    w_door_open;
   logic [N_CARS-1:0]    w_arrive;
   logic                 r_grant_valid;
   logic                 r_req_err;
   logic [CAR_W-1:0]     r_grant_car;
   logic [WAIT_W-1:0]    r_grant_wait;

   assign o_req_ready = !i_rst;
   assign w_legal     = (i_req_floor != '0) && (i_req_floor <= MAX_FLOOR);
   assign w_accept    = i_req_valid && o_req_ready && w_legal;
   assign w_illegal   = i_req_valid && o_req_ready && !w_legal;
   assign w_car       = CAR_W'(floor_to_car(int'(i_req_floor), ZONE));

   // Wait estimate uses the owning car's position as it stands at acceptance.
   always_comb begin
      w_sel_floor = '0;
      for (int k = 0; k < N_CARS; k++) begin
         if (CAR_W'(k) == w_car) w_sel_floor = w_car_floor[k*FW +: FW];
      end
   end

   assign w_dist      = (w_sel_floor > i_req_floor) ? (w_sel_floor - i_req_floor)
                                                    : (i_req_floor - w_sel_floor);
   assign w_wait_full = 48'(w_dist) * 48'(TRAVEL_CYC);
   assign w_wait      = (|w_wait_full[47:WAIT_W]) ? {WAIT_W{1'b1}} : w_wait_full[WAIT_W-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_grant_valid <= 1'b0;
         r_req_err     <= 1'b0;
         r_grant_car   <= '0;
         r_grant_wait  <= '0;
      end else begin
         r_grant_valid <= w_accept;
         r_req_err     <= w_illegal;
         if (w_accept) begin
            r_grant_car  <= w_car;
            r_grant_wait <= w_wait;
         end
      end
   end

   for (genvar k = 0; k < N_CARS; k++) begin : g_car
      localparam int BASE = k * ZONE + 1;
      localparam int TOP  = ((k + 1) * ZONE < N_FLOORS) ? (k + 1) * ZONE : N_FLOORS;

      lift_car #(
         .FW         (FW),
         .ZONE       (ZONE),
         .BASE       (BASE),
         .TOP        (TOP),
         .TRAVEL_CYC (TRAVEL_CYC),
         .DOOR_CYC   (DOOR_CYC)
      ) u_car (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_set_valid (w_accept && (w_car == CAR_W'(k))),
         .i_set_floor (i_req_floor),
         .o_floor     (w_car_floor[k*FW +: FW]),
         .o_moving    (w_car_moving[k]),
         .o_door_open (w_door_open[k]),
         .o_arrive    (w_arrive[k])
      );
   end

   assign o_grant_valid = r_grant_valid;
   assign o_req_err     = r_req_err;
   assign o_grant_car   = r_grant_car;
   assign o_grant_wait  = r_grant_wait;
   assign o_car_floor   = w_car_floor;
   assign o_car_moving  = w_car_moving;
   assign o_door_open   = w_door_open;
   assign o_arrive      = w_arrive;

endmodule
